// File: rtl/test_monitor_pkg.sv
// Shared definitions for the test status monitor.
// Holds the verdict codes, the FSM state encoding and the event channel-index width.
package test_monitor_pkg;

    localparam int CHAN_W = 4;

    localparam logic [2:0] VERDICT_NONE    = 3'd0;
    localparam logic [2:0] VERDICT_PASS    = 3'd1;
    localparam logic [2:0] VERDICT_FAIL    = 3'd2;
    localparam logic [2:0] VERDICT_TIMEOUT = 3'd3;
    localparam logic [2:0] VERDICT_STALL   = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } mon_state_e;

endpackage

// File: rtl/test_event_fifo.sv
// Synchronous show-ahead FIFO for progress events.
// The head entry and the full/empty flags are held in registers.
module test_event_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_ptr_nx_s;
    logic [AW:0]      count_r;
    logic [AW:0]      count_next_s;
    logic [WIDTH-1:0] rd_data_r;
    logic             full_r;
    logic             empty_r;
    logic             do_wr_s;
    logic             do_rd_s;

    // Accept/issue decisions and the next occupancy
    always_comb begin
        do_rd_s      = rd_en && !empty_r;
        do_wr_s      = wr_en && (!full_r || do_rd_s);
        rd_ptr_nx_s  = rd_ptr_r + AW'(1);
        count_next_s = count_r;
        case ({do_wr_s, do_rd_s})
            2'b10:   count_next_s = count_r + (AW+1)'(1);
            2'b01:   count_next_s = count_r - (AW+1)'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, flags and the registered head entry
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            rd_data_r <= '0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_nx_s;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == (AW+1)'(DEPTH));
            empty_r <= (count_next_s == (AW+1)'(0));
            // Head follows the next stored entry, or the bypassed write when that is the only one
            if (do_rd_s) begin
                if (count_r > (AW+1)'(1)) begin
                    rd_data_r <= mem_r[rd_ptr_nx_s];
                end else if (do_wr_s) begin
                    rd_data_r <= wr_data;
                end else begin
                    rd_data_r <= rd_data_r;
                end
            end else if (empty_r && do_wr_s) begin
                rd_data_r <= wr_data;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign full    = full_r;
    assign empty   = empty_r;
    assign rd_data = rd_data_r;

endmodule

// File: rtl/test_status_monitor.sv
// Watches CHANNELS progress/pass/fail register sets, queues progress-change events and
// latches one final verdict (fail, pass, stall or timeout) followed by a grace period.
module test_status_monitor
    import test_monitor_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_CLOCKS  = 1000000,
    parameter int STALL_LIMIT = 0,
    parameter int END_DELAY   = 2,
    parameter int EVT_DEPTH   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0] progress,
    input  logic [CHANNELS*DATA_WIDTH-1:0] pass_word,
    input  logic [CHANNELS*DATA_WIDTH-1:0] fail_word,
    output logic                           evt_valid,
    input  logic                           evt_ready,
    output logic [CHAN_W-1:0]              evt_chan,
    output logic [DATA_WIDTH-1:0]          evt_data,
    output logic                           evt_drop,
    output logic                           done,
    output logic [2:0]                     verdict,
    output logic [CHAN_W-1:0]              verdict_chan,
    output logic [DATA_WIDTH-1:0]          verdict_data,
    output logic [31:0]                    cycle_count
);

    localparam int          EVT_W         = CHAN_W + DATA_WIDTH;
    localparam logic [31:0] MAX_CLOCKS_C  = 32'(MAX_CLOCKS);
    localparam logic [31:0] STALL_LIMIT_C = 32'(STALL_LIMIT);
    localparam logic [31:0] END_DELAY_C   = 32'(END_DELAY);

    mon_state_e            state_r;
    mon_state_e            state_next_s;
    logic [DATA_WIDTH-1:0] shadow_r [CHANNELS];
    logic [CHANNELS-1:0]   pending_r;
    logic [CHANNELS-1:0]   pending_next_s;
    logic [CHANNELS-1:0]   change_s;
    logic [CHANNELS-1:0]   push_onehot_s;
    logic [CHANNELS-1:0]   push_clear_s;
    logic                  drop_s;
    logic                  push_valid_s;
    logic [CHAN_W-1:0]     push_chan_s;
    logic [DATA_WIDTH-1:0] push_data_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [EVT_W-1:0]      fifo_rd_s;
    logic [31:0]           stall_cnt_r;
    logic [31:0]           cycle_count_r;
    logic [31:0]           grace_r;
    logic                  fail_hit_s;
    logic [CHAN_W-1:0]     fail_chan_s;
    logic [DATA_WIDTH-1:0] fail_data_s;
    logic                  pass_hit_s;
    logic [CHAN_W-1:0]     pass_chan_s;
    logic [DATA_WIDTH-1:0] pass_data_s;
    logic                  hit_s;
    logic [2:0]            hit_code_s;
    logic [CHAN_W-1:0]     hit_chan_s;
    logic [DATA_WIDTH-1:0] hit_data_s;
    logic                  evt_drop_r;
    logic                  done_r;
    logic [2:0]            verdict_r;
    logic [CHAN_W-1:0]     verdict_chan_r;
    logic [DATA_WIDTH-1:0] verdict_data_r;

    // Per-channel change detection against the shadow copy; stops once the verdict is final
    always_comb begin
        change_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            change_s[c] = (state_r != ST_DONE) &&
                          (progress[c*DATA_WIDTH +: DATA_WIDTH] != shadow_r[c]);
        end
    end

    // Lowest-index pending channel and its shadow value
    always_comb begin
        push_valid_s  = |pending_r;
        push_onehot_s = pending_r & (~pending_r + CHANNELS'(1));
        push_chan_s   = '0;
        push_data_s   = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            push_chan_s = pending_r[c] ? CHAN_W'(c) : push_chan_s;
            push_data_s = pending_r[c] ? shadow_r[c] : push_data_s;
        end
    end

    assign pop_s  = !fifo_empty_s && evt_ready;
    assign push_s = push_valid_s && (!fifo_full_s || pop_s);

    // A change on a channel still waiting (and not leaving this cycle) overwrites the older value
    always_comb begin
        push_clear_s   = push_s ? push_onehot_s : '0;
        pending_next_s = (pending_r & ~push_clear_s) | change_s;
        drop_s         = |(change_s & pending_r & ~push_clear_s);
    end

    // Lowest-index fail and pass channels
    always_comb begin
        fail_hit_s  = 1'b0;
        fail_chan_s = '0;
        fail_data_s = '0;
        pass_hit_s  = 1'b0;
        pass_chan_s = '0;
        pass_data_s = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (fail_word[c*DATA_WIDTH +: DATA_WIDTH] != '0) begin
                fail_hit_s  = 1'b1;
                fail_chan_s = CHAN_W'(c);
                fail_data_s = fail_word[c*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                fail_hit_s  = fail_hit_s;
            end
            if (pass_word[c*DATA_WIDTH +: DATA_WIDTH] != '0) begin
                pass_hit_s  = 1'b1;
                pass_chan_s = CHAN_W'(c);
                pass_data_s = pass_word[c*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                pass_hit_s  = pass_hit_s;
            end
        end
    end

    // Verdict arbitration, only while running: FAIL > PASS > STALL > TIMEOUT
    always_comb begin
        hit_s      = 1'b0;
        hit_code_s = VERDICT_NONE;
        hit_chan_s = '0;
        hit_data_s = '0;
        if (state_r != ST_RUN) begin
            hit_s = 1'b0;
        end else if (fail_hit_s) begin
            hit_s      = 1'b1;
            hit_code_s = VERDICT_FAIL;
            hit_chan_s = fail_chan_s;
            hit_data_s = fail_data_s;
        end else if (pass_hit_s) begin
            hit_s      = 1'b1;
            hit_code_s = VERDICT_PASS;
            hit_chan_s = pass_chan_s;
            hit_data_s = pass_data_s;
        end else if ((STALL_LIMIT != 0) && (stall_cnt_r == STALL_LIMIT_C)) begin
            hit_s      = 1'b1;
            hit_code_s = VERDICT_STALL;
            hit_data_s = DATA_WIDTH'(cycle_count_r);
        end else if ((MAX_CLOCKS != 0) && (cycle_count_r == MAX_CLOCKS_C)) begin
            hit_s      = 1'b1;
            hit_code_s = VERDICT_TIMEOUT;
            hit_data_s = DATA_WIDTH'(cycle_count_r);
        end else begin
            hit_s = 1'b0;
        end
    end

    // Next-state logic; DRAIN exits once the grace count reaches its last cycle
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN:   state_next_s = hit_s ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_next_s = (grace_r <= 32'd1) ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_next_s = ST_DONE;
            default:  state_next_s = ST_RUN;
        endcase
    end

    // Shadow and pending registers; shadows track live progress during reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                shadow_r[c] <= progress[c*DATA_WIDTH +: DATA_WIDTH];
            end
            pending_r <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (change_s[c]) begin
                    shadow_r[c] <= progress[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            pending_r <= pending_next_s;
        end
    end

    // Sticky coalescing flag
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_drop_r <= 1'b0;
        end else begin
            evt_drop_r <= evt_drop_r | drop_s;
        end
    end

    // Stall watchdog: cycles since the last detected change, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (|change_s) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_cnt_r != 32'hFFFF_FFFF) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    // Cycle counter advances only while the block stays in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count_r <= 32'd0;
        end else if ((state_r == ST_RUN) && !hit_s) begin
            cycle_count_r <= cycle_count_r + 32'd1;
        end
    end

    // State register and grace countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
            grace_r <= 32'd0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == ST_RUN) && hit_s) begin
                grace_r <= END_DELAY_C;
            end else if ((state_r == ST_DRAIN) && (grace_r != 32'd0)) begin
                grace_r <= grace_r - 32'd1;
            end
        end
    end

    // Verdict capture on leaving RUN and the done flag
    always_ff @(posedge clk) begin
        if (rst) begin
            verdict_r      <= VERDICT_NONE;
            verdict_chan_r <= '0;
            verdict_data_r <= '0;
            done_r         <= 1'b0;
        end else begin
            if ((state_r == ST_RUN) && hit_s) begin
                verdict_r      <= hit_code_s;
                verdict_chan_r <= hit_chan_s;
                verdict_data_r <= hit_data_s;
            end
            done_r <= (state_next_s == ST_DONE);
        end
    end

    test_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (EVT_DEPTH)
    ) u_evt_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_s),
        .wr_data ({push_chan_s, push_data_s}),
        .full    (fifo_full_s),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_s),
        .empty   (fifo_empty_s)
    );

    assign evt_valid    = !fifo_empty_s;
    assign evt_chan     = fifo_rd_s[EVT_W-1 -: CHAN_W];
    assign evt_data     = fifo_rd_s[DATA_WIDTH-1:0];
    assign evt_drop     = evt_drop_r;
    assign done         = done_r;
    assign verdict      = verdict_r;
    assign verdict_chan = verdict_chan_r;
    assign verdict_data = verdict_data_r;
    assign cycle_count  = cycle_count_r;

endmodule

// File: tb/tb_test_status_monitor.sv
// Self-checking bench for test_status_monitor: scoreboarded events on a shallow-FIFO instance
// with timeout limit, plus a stall-watchdog instance.
module tb_test_status_monitor;
    import test_monitor_pkg::*;

    localparam int CH = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_a = 1'b1;
    logic [CH*DW-1:0]  prog_a = '0;
    logic [CH*DW-1:0]  pass_a = '0;
    logic [CH*DW-1:0]  fail_a = '0;
    logic              ready_a = 1'b1;
    logic              valid_a, drop_a, done_a;
    logic [3:0]        chan_a, vchan_a;
    logic [DW-1:0]     data_a, vdata_a;
    logic [2:0]        verd_a;
    logic [31:0]       cc_a;

    logic              rst_b = 1'b1;
    logic [CH*DW-1:0]  prog_b = '0;
    logic [CH*DW-1:0]  pass_b = '0;
    logic [CH*DW-1:0]  fail_b = '0;
    logic              ready_b = 1'b1;
    logic              valid_b, drop_b, done_b;
    logic [3:0]        chan_b, vchan_b;
    logic [DW-1:0]     data_b, vdata_b;
    logic [2:0]        verd_b;
    logic [31:0]       cc_b;

    int n_cmp = 0;
    int n_err = 0;
    logic [35:0] exp_q[$];
    logic [35:0] ev;

    test_status_monitor #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .MAX_CLOCKS(100), .STALL_LIMIT(0),
        .END_DELAY(2), .EVT_DEPTH(2)
    ) dut_a (
        .clk(clk), .rst(rst_a), .progress(prog_a), .pass_word(pass_a), .fail_word(fail_a),
        .evt_valid(valid_a), .evt_ready(ready_a), .evt_chan(chan_a), .evt_data(data_a),
        .evt_drop(drop_a), .done(done_a), .verdict(verd_a), .verdict_chan(vchan_a),
        .verdict_data(vdata_a), .cycle_count(cc_a)
    );

    test_status_monitor #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .MAX_CLOCKS(0), .STALL_LIMIT(10),
        .END_DELAY(0), .EVT_DEPTH(8)
    ) dut_b (
        .clk(clk), .rst(rst_b), .progress(prog_b), .pass_word(pass_b), .fail_word(fail_b),
        .evt_valid(valid_b), .evt_ready(ready_b), .evt_chan(chan_b), .evt_data(data_b),
        .evt_drop(drop_b), .done(done_b), .verdict(verd_b), .verdict_chan(vchan_b),
        .verdict_data(vdata_b), .cycle_count(cc_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_a(input logic rdy);
        rst_a   = 1'b1;
        ready_a = rdy;
        pass_a  = '0;
        fail_a  = '0;
        cyc();
        cyc();
        exp_q.delete();
        rst_a = 1'b0;
    endtask

    // Event scoreboard: every accepted event must match the oldest expectation
    always @(negedge clk) begin
        if (!rst_a && valid_a && ready_a) begin
            ev = (exp_q.size() != 0) ? exp_q.pop_front() : 36'hF_FFFF_FFFF;
            chk("evt_chan", 64'(chan_a), 64'(ev[35:32]));
            chk("evt_data", 64'(data_a), 64'(ev[31:0]));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] cc_hold;

        // Reset values and single change latency
        reset_a(1'b1);
        chk("rst_valid", 64'(valid_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_verdict", 64'(verd_a), 64'(VERDICT_NONE));
        chk("rst_cc", 64'(cc_a), 64'd0);
        chk("rst_drop", 64'(drop_a), 64'd0);
        cyc();
        prog_a[2*DW +: DW] = 32'h11;
        exp_q.push_back({4'd2, 32'h11});
        chk("lat_n", 64'(valid_a), 64'd0);
        cyc();
        chk("lat_n1", 64'(valid_a), 64'd0);
        cyc();
        chk("lat_n2", 64'(valid_a), 64'd1);
        repeat (4) cyc();
        chk("single_idle", 64'(valid_a), 64'd0);
        chk("single_drop", 64'(drop_a), 64'd0);
        chk("single_sb", 64'(exp_q.size()), 64'd0);

        // Simultaneous changes against a full two-entry FIFO
        reset_a(1'b0);
        cyc();
        prog_a[0*DW +: DW] = 32'hA0;
        prog_a[1*DW +: DW] = 32'hA1;
        prog_a[3*DW +: DW] = 32'hA3;
        exp_q.push_back({4'd0, 32'hA0});
        exp_q.push_back({4'd1, 32'hA1});
        repeat (4) cyc();
        chk("bp_valid", 64'(valid_a), 64'd1);
        chk("bp_chan", 64'(chan_a), 64'd0);
        chk("bp_data", 64'(data_a), 64'hA0);
        chk("bp_nodrop", 64'(drop_a), 64'd0);
        prog_a[3*DW +: DW] = 32'hB3;
        exp_q.push_back({4'd3, 32'hB3});
        cyc();
        chk("bp_stable", 64'(chan_a), 64'd0);
        cyc();
        chk("bp_drop", 64'(drop_a), 64'd1);
        ready_a = 1'b1;
        repeat (6) cyc();
        chk("bp_idle", 64'(valid_a), 64'd0);
        chk("bp_sb", 64'(exp_q.size()), 64'd0);
        chk("bp_sticky", 64'(drop_a), 64'd1);

        // Simultaneous pass and fail: fail wins, done after the grace period
        reset_a(1'b1);
        cyc();
        pass_a[1*DW +: DW] = 32'h1;
        fail_a[3*DW +: DW] = 32'hDEAD;
        chk("v_none", 64'(verd_a), 64'(VERDICT_NONE));
        cyc();
        chk("v_code", 64'(verd_a), 64'(VERDICT_FAIL));
        chk("v_chan", 64'(vchan_a), 64'd3);
        chk("v_data", 64'(vdata_a), 64'hDEAD);
        chk("v_done1", 64'(done_a), 64'd0);
        cyc();
        chk("v_done2", 64'(done_a), 64'd0);
        cyc();
        chk("v_done3", 64'(done_a), 64'd1);
        pass_a = '0;
        fail_a = '0;
        repeat (3) cyc();
        chk("v_hold", 64'(verd_a), 64'(VERDICT_FAIL));
        chk("v_done_hold", 64'(done_a), 64'd1);
        chk("v_cc_frozen", 64'(cc_a), 64'd1);

        // Pass on two channels: lowest index reported
        reset_a(1'b1);
        cyc();
        pass_a[2*DW +: DW] = 32'h5;
        pass_a[1*DW +: DW] = 32'h7;
        cyc();
        chk("p_code", 64'(verd_a), 64'(VERDICT_PASS));
        chk("p_chan", 64'(vchan_a), 64'd1);
        chk("p_data", 64'(vdata_a), 64'h7);

        // Global cycle limit
        reset_a(1'b1);
        chk("to_start", 64'(cc_a), 64'd0);
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            cyc();
            n = i;
            if (verd_a != VERDICT_NONE) break;
        end
        chk("to_cycle", 64'(n), 64'd101);
        chk("to_code", 64'(verd_a), 64'(VERDICT_TIMEOUT));
        chk("to_data", 64'(vdata_a), 64'd100);
        chk("to_chan", 64'(vchan_a), 64'd0);
        cc_hold = cc_a;
        repeat (5) cyc();
        chk("to_cc", 64'(cc_hold), 64'd100);
        chk("to_cc_frozen", 64'(cc_a), 64'd100);
        chk("to_done", 64'(done_a), 64'd1);

        // Stall watchdog on the second instance
        rst_b = 1'b1;
        cyc();
        cyc();
        rst_b = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            repeat (5) begin
                cyc();
                chk("st_none", 64'(verd_b), 64'(VERDICT_NONE));
            end
            prog_b[(i % 4)*DW +: DW] = 32'(i);
        end
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            n = i;
            if (verd_b != VERDICT_NONE) break;
        end
        chk("st_cycle", 64'(n), 64'd12);
        chk("st_code", 64'(verd_b), 64'(VERDICT_STALL));
        chk("st_data", 64'(vdata_b), 64'd61);
        chk("st_chan", 64'(vchan_b), 64'd0);
        chk("st_done0", 64'(done_b), 64'd0);
        cyc();
        chk("st_done1", 64'(done_b), 64'd1);

        // Reset while draining with events queued
        reset_a(1'b0);
        cyc();
        prog_a[0*DW +: DW] = 32'hC0;
        prog_a[1*DW +: DW] = 32'hC1;
        prog_a[2*DW +: DW] = 32'hC2;
        exp_q.push_back({4'd0, 32'hC0});
        exp_q.push_back({4'd1, 32'hC1});
        exp_q.push_back({4'd2, 32'hC2});
        repeat (3) cyc();
        fail_a[0*DW +: DW] = 32'h9;
        cyc();
        chk("mr_drain", 64'(verd_a), 64'(VERDICT_FAIL));
        chk("mr_queued", 64'(valid_a), 64'd1);
        rst_a  = 1'b1;
        fail_a = '0;
        cyc();
        chk("mr_done", 64'(done_a), 64'd0);
        chk("mr_verdict", 64'(verd_a), 64'(VERDICT_NONE));
        chk("mr_valid", 64'(valid_a), 64'd0);
        chk("mr_cc", 64'(cc_a), 64'd0);
        chk("mr_vdata", 64'(vdata_a), 64'd0);
        exp_q.delete();
        ready_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        repeat (10) cyc();
        chk("mr_quiet", 64'(valid_a), 64'd0);
        chk("mr_drop", 64'(drop_a), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
